// File: rtl/riscv_alu_pkg.sv
// ---------------------------------------------------------------------------
// riscv_alu_pkg
// Shared definitions for the ALU control decoder and the execute stage:
//   - 4-bit ALU operation codes
//   - execute-stage FSM state encoding
//   - serial shifter direction/fill select
//   - default operand width
// ---------------------------------------------------------------------------
package riscv_alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Operation codes as produced by the ALU control decoder
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;  // also BEQ: taken = zero
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } exec_state_e;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,   // left, zero fill
        SH_RL = 2'd1,   // right, zero fill
        SH_RA = 2'd2    // right, sign fill
    } shift_mode_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
// Handshake and data bundle between the ALU control decoder (master side),
// the execute unit (slave side) and the result consumer.
//   in_valid/in_ready  : operation offer / accept
//   alu_ctrl/op_a/op_b : operation code and operands
//   flush              : synchronous abort of any in-flight operation
//   out_valid/out_ready: result offer / take
//   result/zero/taken  : result value and flags
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            taken;

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, flush, out_ready,
        output in_ready, out_valid, result, zero, taken
    );

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, flush, out_ready,
        input  in_ready, out_valid, result, zero, taken
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// ---------------------------------------------------------------------------
// alu_serial_shifter
// Iterative one-bit-per-cycle shifter used by the execute stage.
//   clk, rst_n : clock, asynchronous active-low reset (counter only)
//   load_i     : capture data_i/shamt_i/mode_i into the working state
//   step_i     : perform one single-bit shift and decrement the counter
//   clear_i    : abandon the current shift (counter back to 0)
//   mode_i     : direction / fill select
//   data_i     : value to be shifted
//   shamt_i    : number of single-bit steps
//   data_o     : working value after the step taken this cycle
//   last_o     : the step taken this cycle is the final one
// ---------------------------------------------------------------------------
module alu_serial_shifter
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic                     step_i,
    input  logic                     clear_i,
    input  shift_mode_e              mode_i,
    input  logic [XLEN-1:0]          data_i,
    input  logic [$clog2(XLEN)-1:0]  shamt_i,
    output logic [XLEN-1:0]          data_o,
    output logic                     last_o
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    shift_mode_e     mode_q;
    logic            sign_q;

    // Single-bit step; SRA fills with the sign bit captured at load time
    always_comb begin
        work_d = work_q;
        unique case (mode_q)
            SH_LL:   work_d = {work_q[XLEN-2:0], 1'b0};
            SH_RL:   work_d = {1'b0, work_q[XLEN-1:1]};
            SH_RA:   work_d = {sign_q, work_q[XLEN-1:1]};
            default: work_d = work_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = shamt_i;
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (step_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - SHW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Data path carries no reset; it is always loaded before use
    always_ff @(posedge clk) begin
        if (load_i) begin
            work_q <= data_i;
            mode_q <= mode_i;
            sign_q <= data_i[XLEN-1];
        end else if (step_i) begin
            work_q <= work_d;
        end
    end

    assign data_o = work_d;
    assign last_o = (cnt_q == SHW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle execute stage behind the ALU control decoder. Logic,
// arithmetic and compare operations finish in one cycle; shifts iterate
// one bit per cycle in alu_serial_shifter.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   exe_if : slave side of alu_exec_unit_if
//            (in_valid/in_ready, alu_ctrl, op_a, op_b, flush,
//             out_valid/out_ready, result, zero, taken)
// ---------------------------------------------------------------------------
module alu_exec_unit
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave exe_if
);
    localparam int SHW = $clog2(XLEN);

    exec_state_e state_q, state_d;

    logic              accept;
    logic              is_shift;
    logic              long_shift;
    logic [SHW-1:0]    shamt;
    shift_mode_e       sh_mode;
    logic              sh_load;
    logic              sh_step;
    logic              sh_last;
    logic [XLEN-1:0]   sh_data;

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [XLEN-1:0]   diff;
    logic              lt_s;
    logic              lt_u;
    logic [XLEN-1:0]   alu_res;
    logic              alu_taken;

    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              taken_q, taken_d;

    assign shamt      = exe_if.op_b[SHW-1:0];
    assign is_shift   = is_shift_op(exe_if.alu_ctrl);
    assign long_shift = is_shift && (shamt != '0);
    // flush wins over in_valid: a flushed offer is never accepted
    assign accept     = (state_q == ST_IDLE) && exe_if.in_valid && !exe_if.flush;

    // ---------------- single-cycle operations ----------------
    assign a_s  = exe_if.op_a;
    assign b_s  = exe_if.op_b;
    assign diff = exe_if.op_a - exe_if.op_b;
    assign lt_s = a_s < b_s;
    assign lt_u = exe_if.op_a < exe_if.op_b;

    always_comb begin
        alu_res   = '0;
        alu_taken = 1'b0;
        unique case (exe_if.alu_ctrl)
            ALU_AND:  alu_res = exe_if.op_a & exe_if.op_b;
            ALU_OR:   alu_res = exe_if.op_a | exe_if.op_b;
            ALU_ADD:  alu_res = exe_if.op_a + exe_if.op_b;
            ALU_XOR:  alu_res = exe_if.op_a ^ exe_if.op_b;
            ALU_SUB: begin
                alu_res   = diff;
                alu_taken = (diff == '0);
            end
            ALU_BNE: begin
                alu_res   = diff;
                alu_taken = (diff != '0);
            end
            ALU_BLT: begin
                alu_res   = {{(XLEN-1){1'b0}}, lt_s};
                alu_taken = lt_s;
            end
            ALU_BGE: begin
                alu_res   = {{(XLEN-1){1'b0}}, !lt_s};
                alu_taken = !lt_s;
            end
            ALU_BLTU: begin
                alu_res   = {{(XLEN-1){1'b0}}, lt_u};
                alu_taken = lt_u;
            end
            ALU_BGEU: begin
                alu_res   = {{(XLEN-1){1'b0}}, !lt_u};
                alu_taken = !lt_u;
            end
            // Zero-amount shifts pass op_a straight through
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = exe_if.op_a;
            default: begin
                alu_res   = '0;
                alu_taken = 1'b0;
            end
        endcase
    end

    always_comb begin
        sh_mode = SH_LL;
        if (exe_if.alu_ctrl == ALU_SRL) begin
            sh_mode = SH_RL;
        end else if (exe_if.alu_ctrl == ALU_SRA) begin
            sh_mode = SH_RA;
        end
    end

    alu_serial_shifter #(
        .XLEN (XLEN)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sh_load),
        .step_i  (sh_step),
        .clear_i (exe_if.flush),
        .mode_i  (sh_mode),
        .data_i  (exe_if.op_a),
        .shamt_i (shamt),
        .data_o  (sh_data),
        .last_o  (sh_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = long_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (sh_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (exe_if.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (exe_if.flush) begin
            state_d = ST_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        exe_if.in_ready  = (state_q == ST_IDLE);
        exe_if.out_valid = (state_q == ST_DONE);
        sh_load          = accept && long_shift;
        sh_step          = (state_q == ST_SHIFT) && !exe_if.flush;
    end

    // ---------------- result registers ----------------
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        taken_d  = taken_q;
        if (accept && !long_shift) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            taken_d  = alu_taken;
        end else if (sh_step && sh_last) begin
            result_d = sh_data;
            zero_d   = (sh_data == '0);
            taken_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            taken_q  <= taken_d;
        end
    end

    assign exe_if.result = result_q;
    assign exe_if.zero   = zero_q;
    assign exe_if.taken  = taken_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
// Latency is counted in rising edges, including the accepting edge, until
// out_valid is seen.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
    import riscv_alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(
        .XLEN (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .exe_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_taken,
                          input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs after acceptance; the unit must ignore them
        bus.in_valid = 1'b0;
        bus.alu_ctrl = ALU_ADD;
        bus.op_a     = 32'hDEADBEEF;
        bus.op_b     = 32'h00000005;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
        chk({tag, "_taken"}, {31'd0, bus.taken}, {31'd0, exp_taken});
        chk({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            chk({tag, "_hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
            chk({tag, "_hold_result"}, bus.result, exp_res);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_drain"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'd0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd0);
        chk("rst_taken", {31'd0, bus.taken}, 32'd0);

        //      tag     code      a             b             result        z     t     lat hold
        run_op("add",  ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1,  0);
        run_op("sub",  ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1,  0);
        run_op("and",  ALU_AND,  32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0, 1'b0, 1,  0);
        run_op("or",   ALU_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0, 1,  0);
        run_op("xor",  ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1,  10);
        run_op("blt",  ALU_BLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1,  0);
        run_op("bltu", ALU_BLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1,  0);
        run_op("bge",  ALU_BGE,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1,  0);
        run_op("bgeu", ALU_BGEU, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1,  0);
        run_op("bne",  ALU_BNE,  32'h00000003, 32'h00000004, 32'hFFFFFFFF, 1'b0, 1'b1, 1,  0);
        run_op("rsvd", 4'b0101,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1,  0);
        run_op("sra4", ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 5,  0);
        run_op("sra1", ALU_SRA,  32'h40000000, 32'h00000001, 32'h20000000, 1'b0, 1'b0, 2,  0);
        run_op("sll0", ALU_SLL,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1,  0);
        run_op("srl31",ALU_SRL,  32'hFFFFFFFF, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 32, 0);
        run_op("sll31",ALU_SLL,  32'h00000003, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 32, 0);
        run_op("sll2z",ALU_SLL,  32'hC0000000, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 3,  0);

        // flush in the middle of a 10-step shift
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ALU_SLL;
        bus.op_a     = 32'h00000001;
        bus.op_b     = 32'h0000000A;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("flsh_busy", {31'd0, bus.in_ready}, 32'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flsh_idle", {31'd0, bus.in_ready}, 32'd1);
        chk("flsh_no_valid", {31'd0, bus.out_valid}, 32'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        chk("flsh_never_valid", seen, 0);

        // flush together with an offer in IDLE drops the offer
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ALU_ADD;
        bus.op_a     = 32'h00000001;
        bus.op_b     = 32'h00000001;
        @(posedge clk);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flidle_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("flidle_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("flidle_valid2", {31'd0, bus.out_valid}, 32'd0);

        run_op("postfl", ALU_BNE, 32'h00000003, 32'h00000004, 32'hFFFFFFFF, 1'b0, 1'b1, 1, 0);

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ALU_SRA;
        bus.op_a     = 32'h80000000;
        bus.op_b     = 32'h00000008;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_result", bus.result, 32'd0);
        chk("arst_taken", {31'd0, bus.taken}, 32'd0);
        chk("arst_zero", {31'd0, bus.zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        chk("arst_op_lost", seen, 0);

        run_op("postrst", ALU_ADD, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute stage directly downstream of the ALU control decoder: consumes the 4-bit ALU operation code plus two operands and produces a result, zero flag and branch-taken flag. Logic, arithmetic and compare ops complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter to save area. Valid/ready handshakes on both sides let the datapath stall on long shifts.

## Interface
- XLEN, 32: operand/result width; shift amount width is log2(XLEN)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept (high only in IDLE)
- alu_ctrl  input  4  operation code (encoding below)
- op_a  input  XLEN  rs1 operand
- op_b  input  XLEN  rs2/immediate operand; shift amount = op_b[log2(XLEN)-1:0]
- flush  input  1  synchronous abort of any in-flight operation
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer takes result
- result  output  XLEN  operation result
- zero  output  1  result == 0
- taken  output  1  branch condition true

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB (BEQ taken = zero), 1000 SLL, 1001 SRL, 1010 SRA, 1011 BNE (result a-b, taken = !zero), 1100 BLT, 1101 BGE, 1110 BLTU, 1111 BGEU.
- BLT/BGE compare signed; BLTU/BGEU unsigned. For these, result = {0…0, cond}, taken = cond.
- taken = 0 for all non-branch codes except 0110.
- Codes 0100, 0101, 0111: result 0, zero 1, taken 0. Complete in one cycle.
- ADD/SUB wrap modulo 2^XLEN. No overflow flag.
- States:
  - IDLE: in_ready = 1. On in_valid, latch operands/code. Go to DONE for non-shift codes or shamt 0. Go to SHIFT for shifts with shamt > 0, loading counter = shamt.
  - SHIFT: shift working register one bit per cycle, decrement counter. On counter reaching 1, go to DONE with final value.
  - DONE: out_valid = 1, outputs stable. On out_ready, go to IDLE.
- SRA fills with the original sign bit each step; SRL and SLL fill with 0.
- flush in any state: go to IDLE next edge, out_valid = 0, no result delivered. flush in IDLE with in_valid: the operation is dropped, not accepted.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, result 0, zero 0, taken 0, counter 0.
- Non-shift or shamt 0: accepted at edge N, out_valid high from edge N+1.
- Shift with shamt k > 0: out_valid high from edge N+1+k; max latency XLEN.
- Throughput: at most one op per two cycles. in_ready is low in DONE, even while out_ready is high.
- out_valid holds and result/zero/taken stay constant until out_ready is sampled high.
- Inputs alu_ctrl/op_a/op_b are sampled only at acceptance; later changes are ignored.
- Async reset mid-SHIFT or mid-DONE: immediate return to reset values, in-flight op lost.

## Structure
- Shared package riscv_alu_pkg holds:
  - 4-bit opcode constants, shared with the ALU control decoder.
  - State enum IDLE/SHIFT/DONE.
  - XLEN default.
- Sub-module alu_serial_shifter: working register, down-counter, direction/arith select, load/step/last outputs.
- The top level holds the FSM, single-cycle ops, compare logic and output registers.

## Test plan
- After reset: in_ready=1, out_valid=0, result=0.
- ADD 0x7FFFFFFF + 1 → result 0x80000000, zero 0, out_valid 1 cycle after accept.
- SUB 5−5 (0110) → result 0, zero 1, taken 1.
- BLT with a=0xFFFFFFFF, b=1 → taken 1; BLTU with the same operands → taken 0; BNE 3,4 → taken 1.
- SRA 0x80000000 by 4 → 0xF8000000 after 5 cycles. SLL by 0 → result a after 1 cycle. SRL 0xFFFFFFFF by 31 → 0x1 after 32 cycles.
- Hold out_ready=0 for 10 cycles: result stable, in_ready=0. Separately:
  - flush mid-SHIFT → IDLE next cycle, no out_valid.
  - rst_n low mid-SHIFT → reset values immediately.
